// File: rtl/axi_bank_delay.sv
// axi_bank_delay
//   Page-aware latency gate for one AXI address channel (AR or AW). It sits
//   between an upstream master and a downstream slave. It keeps one open row
//   per bank and classifies each request as a row HIT, a row MISS or an EMPTY
//   bank. The handshake is then held off for a class-dependent number of
//   cycles, and saturating per-class statistics are kept.
//
//   Optional build macro: AXI_BANK_DELAY_REFRESH_EN adds a periodic refresh.
//   Each refresh closes all banks and blocks new classification for
//   REFRESH_STALL cycles.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   in_valid/ready  upstream address handshake, in_addr request address
//   out_valid/ready downstream address handshake
//   busy            request in flight (WAIT or PASS)
//   last_class      class of last completed transfer: 0 none, 1 hit, 2 empty, 3 miss
//   *_count         saturating completed-transfer counters per class
module axi_bank_delay #(
    parameter int ADDR_WIDTH        = 16,
    parameter int PAGE_OFFSET_WIDTH = 6,
    parameter int BANK_BITS         = 2,
    parameter int DELAY_WIDTH       = 4,
    parameter int HIT_DELAY         = 2,
    parameter int EMPTY_DELAY       = 5,
    parameter int MISS_DELAY        = 8,
    parameter int STAT_WIDTH        = 16,
    parameter int REFRESH_PERIOD    = 256,
    parameter int REFRESH_STALL     = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ADDR_WIDTH-1:0] in_addr,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy,
    output logic [1:0]            last_class,
    output logic [STAT_WIDTH-1:0] hit_count,
    output logic [STAT_WIDTH-1:0] empty_count,
    output logic [STAT_WIDTH-1:0] miss_count
);
    localparam int NUM_BANKS = 2 ** BANK_BITS;
    localparam int ROW_W     = ADDR_WIDTH - PAGE_OFFSET_WIDTH - BANK_BITS;

    localparam logic [1:0] C_HIT   = 2'd1;
    localparam logic [1:0] C_EMPTY = 2'd2;
    localparam logic [1:0] C_MISS  = 2'd3;

    localparam logic [DELAY_WIDTH-1:0] D_HIT   = DELAY_WIDTH'(HIT_DELAY);
    localparam logic [DELAY_WIDTH-1:0] D_EMPTY = DELAY_WIDTH'(EMPTY_DELAY);
    localparam logic [DELAY_WIDTH-1:0] D_MISS  = DELAY_WIDTH'(MISS_DELAY);
    localparam logic [DELAY_WIDTH-1:0] D_ONE   = DELAY_WIDTH'(1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_PASS} state_t;

    state_t                  r_state, w_state_nxt;
    logic [DELAY_WIDTH-1:0]  r_cnt;
    logic [1:0]              r_class;
    logic [NUM_BANKS-1:0]    r_bank_vld;
    logic [ROW_W-1:0]        r_row [NUM_BANKS];
    logic [1:0]              r_last_class;
    logic [STAT_WIDTH-1:0]   r_hit_cnt, r_empty_cnt, r_miss_cnt;

    logic [BANK_BITS-1:0]    w_bank;
    logic [ROW_W-1:0]        w_row;
    logic [1:0]              w_class;
    logic [DELAY_WIDTH-1:0]  w_delay;
    logic                    w_load, w_commit, w_block;
    logic                    w_unused_addr;

    assign w_bank        = in_addr[PAGE_OFFSET_WIDTH +: BANK_BITS];
    assign w_row         = in_addr[ADDR_WIDTH-1 : PAGE_OFFSET_WIDTH+BANK_BITS];
    assign w_unused_addr = ^in_addr[PAGE_OFFSET_WIDTH-1:0];

`ifdef AXI_BANK_DELAY_REFRESH_EN
    localparam int RW = $clog2(REFRESH_PERIOD + 1);
    localparam int SW = $clog2(REFRESH_STALL + 1);

    logic [RW-1:0] r_ref_cnt;
    logic [SW-1:0] r_stall;
    logic          r_ref_pend;
    logic          w_wrap, w_ref_fire;

    assign w_wrap     = (r_ref_cnt == RW'(REFRESH_PERIOD - 1));
    // A refresh that lands in PASS is held pending until the request leaves PASS.
    assign w_ref_fire = (w_wrap || r_ref_pend) && (r_state != S_PASS);
    // The firing cycle itself is blocked too, so nothing classifies against the table being cleared.
    assign w_block    = w_ref_fire || (r_stall != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ref_cnt  <= '0;
            r_ref_pend <= 1'b0;
            r_stall    <= '0;
        end else begin
            r_ref_cnt  <= w_wrap ? '0 : r_ref_cnt + RW'(1);
            if (w_ref_fire)  r_ref_pend <= 1'b0;
            else if (w_wrap) r_ref_pend <= 1'b1;
            if (w_ref_fire)           r_stall <= SW'(REFRESH_STALL);
            else if (r_stall != '0)   r_stall <= r_stall - SW'(1);
        end
    end
`else
    logic w_unused_ref;
    assign w_unused_ref = ^{32'(REFRESH_PERIOD), 32'(REFRESH_STALL)};
    assign w_block      = 1'b0;
`endif

    // Classification uses the table as committed by earlier handshakes only.
    always_comb begin
        w_class = C_EMPTY;
        if (r_bank_vld[w_bank])
            w_class = (r_row[w_bank] == w_row) ? C_HIT : C_MISS;
        case (w_class)
            C_HIT:   w_delay = D_HIT;
            C_MISS:  w_delay = D_MISS;
            default: w_delay = D_EMPTY;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        w_load      = 1'b0;
        w_commit    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (in_valid && !w_block) begin
                    w_load      = 1'b1;
                    w_state_nxt = (w_delay > D_ONE) ? S_WAIT : S_PASS;
                end
            end
            S_WAIT: begin
                if (!in_valid)          w_state_nxt = S_IDLE;
                else if (r_cnt <= D_ONE) w_state_nxt = S_PASS;
            end
            S_PASS: begin
                out_valid = in_valid;
                in_ready  = out_ready;
                if (!in_valid) begin
                    w_state_nxt = S_IDLE;
                end else if (out_ready) begin
                    w_commit    = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_class      <= '0;
            r_bank_vld   <= '0;
            r_last_class <= '0;
            r_hit_cnt    <= '0;
            r_empty_cnt  <= '0;
            r_miss_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load) begin
                r_cnt   <= w_delay - D_ONE;
                r_class <= w_class;
            end else if (r_state == S_WAIT) begin
                r_cnt <= r_cnt - D_ONE;
            end
`ifdef AXI_BANK_DELAY_REFRESH_EN
            if (w_ref_fire) r_bank_vld <= '0;
`endif
            if (w_commit) begin
                r_bank_vld[w_bank] <= 1'b1;
                r_last_class       <= r_class;
                case (r_class)
                    C_HIT:   if (r_hit_cnt   != '1) r_hit_cnt   <= r_hit_cnt   + STAT_WIDTH'(1);
                    C_MISS:  if (r_miss_cnt  != '1) r_miss_cnt  <= r_miss_cnt  + STAT_WIDTH'(1);
                    default: if (r_empty_cnt != '1) r_empty_cnt <= r_empty_cnt + STAT_WIDTH'(1);
                endcase
            end
        end
    end

    // Row storage needs no reset; the bank valid bits qualify it.
    always_ff @(posedge clk) begin
        if (w_commit) r_row[w_bank] <= w_row;
    end

    assign busy        = (r_state != S_IDLE);
    assign last_class  = r_last_class;
    assign hit_count   = r_hit_cnt;
    assign empty_count = r_empty_cnt;
    assign miss_count  = r_miss_cnt;
endmodule

// File: tb/tb_axi_bank_delay.sv
module tb_axi_bank_delay;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_addr;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic [1:0]  last_class;
    logic [15:0] hit_count, empty_count, miss_count;

    int n_checks = 0;
    int n_err    = 0;

    axi_bank_delay dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr),
        .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .last_class(last_class),
        .hit_count(hit_count), .empty_count(empty_count), .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_stats(input string tag, input logic [1:0] cls,
                             input int h, input int e, input int m);
        chk({tag, ".last_class"}, 32'(last_class), 32'(cls));
        chk({tag, ".hit"},        32'(hit_count),  h);
        chk({tag, ".empty"},      32'(empty_count), e);
        chk({tag, ".miss"},       32'(miss_count), m);
    endtask

    // One transfer with out_ready held high: out_valid must first rise
    // exactly d edges after the request is presented.
    task automatic xfer(input string tag, input logic [15:0] a, input int d,
                        input logic [1:0] cls, input int h, input int e, input int m);
        in_addr  = a;
        in_valid = 1'b1;
        for (int k = 1; k <= d; k++) begin
            step();
            chk({tag, ".out_valid"}, 32'(out_valid), 32'(k == d));
            chk({tag, ".in_ready"},  32'(in_ready),  32'(k == d));
            chk({tag, ".busy"},      32'(busy),      32'(1));
        end
        step();
        in_valid = 1'b0;
        chk({tag, ".idle"}, 32'(busy), 32'(0));
        chk_stats(tag, cls, h, e, m);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_addr = '0; out_ready = 1'b1;
        step(); step();
        chk("rst.in_ready",  32'(in_ready),  32'(0));
        chk("rst.out_valid", 32'(out_valid), 32'(0));
        chk("rst.busy",      32'(busy),      32'(0));
        chk_stats("rst", 2'd0, 0, 0, 0);
        rst = 1'b0;
        step();

        xfer("empty0", 16'h0100, 5, 2'd2, 0, 1, 0);
        xfer("hit0",   16'h0120, 2, 2'd1, 1, 1, 0);
        xfer("empty1", 16'h0240, 5, 2'd2, 1, 2, 0);
        xfer("miss0",  16'h0200, 8, 2'd3, 1, 2, 1);
        xfer("hit0b",  16'h0220, 2, 2'd1, 2, 2, 1);

        // Backpressure: bank 0 holds row 0x02, so 0x0120 is a miss.
        out_ready = 1'b0;
        in_addr   = 16'h0120;
        in_valid  = 1'b1;
        for (int k = 1; k <= 8; k++) step();
        chk("bp.out_valid", 32'(out_valid), 32'(1));
        for (int k = 0; k < 3; k++) begin
            step();
            chk("bp.hold_ovld", 32'(out_valid), 32'(1));
            chk("bp.hold_irdy", 32'(in_ready),  32'(0));
            chk("bp.hold_miss", 32'(miss_count), 32'(1));
            chk("bp.hold_busy", 32'(busy),      32'(1));
        end
        out_ready = 1'b1;
        #1;
        chk("bp.in_ready", 32'(in_ready), 32'(1));
        step();
        in_valid = 1'b0;
        chk("bp.idle", 32'(busy), 32'(0));
        chk_stats("bp", 2'd3, 2, 2, 2);

        // Reset while waiting on a miss (bank 0 now holds row 0x01).
        in_addr  = 16'h0200;
        in_valid = 1'b1;
        step(); step(); step();
        chk("rw.busy_before", 32'(busy), 32'(1));
        rst = 1'b1; in_valid = 1'b0;
        step();
        chk("rw.busy",      32'(busy),      32'(0));
        chk("rw.out_valid", 32'(out_valid), 32'(0));
        chk("rw.in_ready",  32'(in_ready),  32'(0));
        chk_stats("rw", 2'd0, 0, 0, 0);
        rst = 1'b0;
        step();
        xfer("post_rst", 16'h0100, 5, 2'd2, 0, 1, 0);

        // Dropping in_valid mid-WAIT aborts without touching the table.
        in_addr  = 16'h0240;
        in_valid = 1'b1;
        step(); step();
        in_valid = 1'b0;
        step();
        chk("abort.busy", 32'(busy), 32'(0));
        chk_stats("abort", 2'd2, 0, 1, 0);
        xfer("abort_retry", 16'h0240, 5, 2'd2, 0, 2, 0);
        xfer("hit_after",   16'h0120, 2, 2'd1, 1, 2, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
